// File: rtl/bicubic_pkg.sv
// Shared constants for the bicubic upsampler: Keys (a = -0.5) phase weights scaled by 128,
// rounding constants and datapath width helpers.
package bicubic_pkg;
    localparam int FRAC_BITS   = 7;
    localparam int ROUND_CONST = 8192;
    localparam int SHIFT       = 14;
    // +128 does not fit in 8 signed bits, so coefficients carry one extra bit.
    localparam int COEF_W      = FRAC_BITS + 2;

    localparam logic signed [COEF_W-1:0] PHASE_W [4][4] = '{
        '{ 9'sd0,  9'sd128,  9'sd0,    9'sd0 },
        '{-9'sd9,  9'sd111,  9'sd29,  -9'sd3 },
        '{-9'sd8,  9'sd72,   9'sd72,  -9'sd8 },
        '{-9'sd3,  9'sd29,   9'sd111, -9'sd9 }
    };

    function automatic int v_width(input int cw);
        return cw + 9;
    endfunction

    function automatic int s_width(input int cw);
        return cw + 18;
    endfunction
endpackage

// File: rtl/bicubic_upsample_pipe_tap4_mac.sv
// One signed 4-tap inner product; OUT_W must hold the exact result, so wrap-around
// arithmetic at OUT_W bits yields the true sum.
module bicubic_tap4_mac
    import bicubic_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int OUT_W = 17
)(
    input  logic signed [IN_W-1:0]   x0,
    input  logic signed [IN_W-1:0]   x1,
    input  logic signed [IN_W-1:0]   x2,
    input  logic signed [IN_W-1:0]   x3,
    input  logic signed [COEF_W-1:0] w0,
    input  logic signed [COEF_W-1:0] w1,
    input  logic signed [COEF_W-1:0] w2,
    input  logic signed [COEF_W-1:0] w3,
    output logic signed [OUT_W-1:0]  y
);
    assign y = OUT_W'(x0) * OUT_W'(w0) + OUT_W'(x1) * OUT_W'(w1)
             + OUT_W'(x2) * OUT_W'(w2) + OUT_W'(x3) * OUT_W'(w3);
endmodule

// File: rtl/bicubic_upsample_pipe.sv
// Two-stage bicubic upsampler: vertical pass into S1, horizontal pass plus round/clamp into S2,
// emitting ROWS_PER_BEAT output rows of the 4x4 interpolated grid per beat.
module bicubic_upsample_pipe
    import bicubic_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 8,
    parameter int CHANNELS      = 3,
    parameter int ROWS_PER_BEAT = 2
)(
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [16*CHANNELS*CHANNEL_WIDTH-1:0]           in_win,
    input  logic                                           in_last,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [ROWS_PER_BEAT*4*CHANNELS*CHANNEL_WIDTH-1:0] out_pix,
    output logic                                           out_last
);
    localparam int         BEATS     = 4 / ROWS_PER_BEAT;
    localparam int         VW        = v_width(CHANNEL_WIDTH);
    localparam int         SW        = s_width(CHANNEL_WIDTH);
    localparam int         PIX_W     = ROWS_PER_BEAT * 4 * CHANNELS * CHANNEL_WIDTH;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    function automatic logic [CHANNEL_WIDTH-1:0] round_clamp(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] r;
        r = (s + SW'(ROUND_CONST)) >>> SHIFT;
        if (r < 0)
            return '0;
        if (r > SW'((1 << CHANNEL_WIDTH) - 1))
            return '1;
        return r[CHANNEL_WIDTH-1:0];
    endfunction

    logic [1:0] beat_cnt;
    logic       vld_p1, last_p1;
    logic       s1_ready, s2_ready, accept, final_beat;
    logic signed [VW-1:0] v_comb [ROWS_PER_BEAT][4][CHANNELS];
    logic signed [VW-1:0] v_p1   [ROWS_PER_BEAT][4][CHANNELS];
    logic [PIX_W-1:0]     pix_comb;

    assign s2_ready   = !out_valid || out_ready;
    assign s1_ready   = !vld_p1 || s2_ready;
    assign final_beat = (beat_cnt == LAST_BEAT);
    assign accept     = in_valid && s1_ready && !rst;
    assign in_ready   = accept && final_beat;

    // Stage 1: vertical taps per column, phase chosen by beat and row within the beat
    for (genvar j = 0; j < ROWS_PER_BEAT; j++) begin : g_s1_row
        logic [1:0] vph;
        assign vph = 2'(int'(beat_cnt) * ROWS_PER_BEAT + j);
        for (genvar c = 0; c < 4; c++) begin : g_col
            for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
                logic signed [CHANNEL_WIDTH:0] x [4];
                logic signed [VW-1:0]          v_out;
                for (genvar r = 0; r < 4; r++) begin : g_tap
                    assign x[r] = {1'b0, in_win[((r*4+c)*CHANNELS+ch)*CHANNEL_WIDTH +: CHANNEL_WIDTH]};
                end
                bicubic_tap4_mac #(.IN_W(CHANNEL_WIDTH + 1), .OUT_W(VW)) u_mac (
                    .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
                    .w0(PHASE_W[vph][0]), .w1(PHASE_W[vph][1]),
                    .w2(PHASE_W[vph][2]), .w3(PHASE_W[vph][3]),
                    .y (v_out)
                );
                assign v_comb[j][c][ch] = v_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            v_p1    <= v_comb;
            last_p1 <= in_last && final_beat;
        end
    end

    // Stage 2: horizontal taps per output column, then round and clamp
    for (genvar j = 0; j < ROWS_PER_BEAT; j++) begin : g_s2_row
        for (genvar i = 0; i < 4; i++) begin : g_col
            for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
                logic signed [SW-1:0] s;
                bicubic_tap4_mac #(.IN_W(VW), .OUT_W(SW)) u_mac (
                    .x0(v_p1[j][0][ch]), .x1(v_p1[j][1][ch]),
                    .x2(v_p1[j][2][ch]), .x3(v_p1[j][3][ch]),
                    .w0(PHASE_W[i][0]), .w1(PHASE_W[i][1]),
                    .w2(PHASE_W[i][2]), .w3(PHASE_W[i][3]),
                    .y (s)
                );
                assign pix_comb[((j*4+i)*CHANNELS+ch)*CHANNEL_WIDTH +: CHANNEL_WIDTH] = round_clamp(s);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept)
                beat_cnt <= final_beat ? 2'd0 : beat_cnt + 2'd1;
            if (s1_ready)
                vld_p1 <= in_valid;
            if (s2_ready)
                out_valid <= vld_p1;
            if (vld_p1 && s2_ready) begin
                out_pix  <= pix_comb;
                out_last <= last_p1;
            end
        end
    end
endmodule

// File: tb/tb_bicubic_upsample_pipe.sv
// Bench for bicubic_upsample_pipe: directed and random windows against a direct 2-D
// weighted-sum reference, with ready back-pressure, latency and reset checks.
module tb_bicubic_upsample_pipe;
    localparam int CW    = 8;
    localparam int CH    = 3;
    localparam int RPB   = 2;
    localparam int BEATS = 4 / RPB;
    localparam int WIN_W = 16 * CH * CW;
    localparam int PIX_W = RPB * 4 * CH * CW;

    typedef struct {
        logic [PIX_W-1:0] pix;
        logic             last;
    } exp_t;

    logic             clk, rst;
    logic             in_valid, in_ready, in_last;
    logic [WIN_W-1:0] in_win;
    logic             out_valid, out_ready, out_last;
    logic [PIX_W-1:0] out_pix;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    logic [3:0] ready_pat = 4'b1001;
    exp_t expq[$];
    exp_t mon_e;
    logic             held_chk = 1'b0;
    logic [PIX_W-1:0] held_pix;
    logic             held_last;

    int wt [4][4] = '{'{0, 128, 0, 0}, '{-9, 111, 29, -3}, '{-8, 72, 72, -8}, '{-3, 29, 111, -9}};

    bicubic_upsample_pipe #(.CHANNEL_WIDTH(CW), .CHANNELS(CH), .ROWS_PER_BEAT(RPB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int sample(input logic [WIN_W-1:0] w, input int r, input int c, input int ch);
        return int'(w[((r*4+c)*CH+ch)*CW +: CW]);
    endfunction

    // Direct 2-D sum over the 16 taps with product weights, floor of (S + 0.5 LSB), clamped.
    function automatic int ref_pix(input logic [WIN_W-1:0] w, input int ch, input int v, input int h);
        int s = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s += wt[v][r] * wt[h][c] * sample(w, r, c, ch);
        s = (s + 8192) >>> 14;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    function automatic logic [WIN_W-1:0] rand_win();
        logic [WIN_W-1:0] w;
        for (int k = 0; k < 16 * CH; k++) begin
            case ($urandom_range(0, 3))
                0:       w[k*CW +: CW] = 8'd0;
                1:       w[k*CW +: CW] = 8'd255;
                default: w[k*CW +: CW] = 8'($urandom_range(0, 255));
            endcase
        end
        return w;
    endfunction

    function automatic logic [WIN_W-1:0] flat_win(input int val);
        logic [WIN_W-1:0] w;
        for (int k = 0; k < 16 * CH; k++)
            w[k*CW +: CW] = 8'(val);
        return w;
    endfunction

    task automatic expect_window(input logic [WIN_W-1:0] w, input logic l);
        exp_t e;
        for (int b = 0; b < BEATS; b++) begin
            e.pix = '0;
            for (int j = 0; j < RPB; j++)
                for (int i = 0; i < 4; i++)
                    for (int ch = 0; ch < CH; ch++)
                        e.pix[((j*4+i)*CH+ch)*CW +: CW] = 8'(ref_pix(w, ch, b*RPB + j, i));
            e.last = l && (b == BEATS - 1);
            expq.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ready_pat[cyc % 4];
            2:       out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    endtask

    task automatic send(input logic [WIN_W-1:0] w, input logic l);
        logic got;
        int   n;
        expect_window(w, l);
        in_win   = w;
        in_last  = l;
        in_valid = 1'b1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            got = in_ready;
            step();
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL send_timeout got in_ready=0 required 1 within 200 cycles");
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while ((expq.size() != 0 || out_valid) && n < 300) begin
            step();
            n++;
        end
        checks++;
        assert (expq.size() == 0) else begin
            errors++;
            $error("FAIL drain got %0d beats outstanding required 0", expq.size());
        end
    endtask

    // Output monitor: scoreboard on every transfer, hold check across stalls.
    always @(negedge clk) begin
        if (rst) begin
            held_chk = 1'b0;
        end else begin
            if (held_chk) begin
                checks++;
                assert (out_valid === 1'b1 && out_pix === held_pix && out_last === held_last) else begin
                    errors++;
                    $error("FAIL stall_hold got v=%b last=%b pix=%h required v=1 last=%b pix=%h",
                           out_valid, out_last, out_pix, held_last, held_pix);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL extra_beat got pix=%h required no beat", out_pix);
                end else begin
                    mon_e = expq.pop_front();
                    checks++;
                    assert (out_pix === mon_e.pix) else begin
                        errors++;
                        $error("FAIL beat_pix got %h required %h", out_pix, mon_e.pix);
                    end
                    checks++;
                    assert (out_last === mon_e.last) else begin
                        errors++;
                        $error("FAIL beat_last got %b required %b", out_last, mon_e.last);
                    end
                end
            end
            held_chk  = out_valid && !out_ready;
            held_pix  = out_pix;
            held_last = out_last;
        end
    end

    initial begin
        logic [WIN_W-1:0] w;
        rst = 1'b1; in_valid = 1'b0; in_win = '0; in_last = 1'b0; out_ready = 1'b0;
        ready_mode = 3;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_out_valid got %b required 0", out_valid); end
        checks++;
        assert (out_pix === '0) else begin errors++; $error("FAIL rst_out_pix got %h required 0", out_pix); end
        checks++;
        assert (out_last === 1'b0) else begin errors++; $error("FAIL rst_out_last got %b required 0", out_last); end
        checks++;
        assert (in_ready === 1'b0) else begin errors++; $error("FAIL rst_in_ready got %b required 0", in_ready); end

        // Latency: flat window, unstalled, first beat visible two edges after acceptance.
        ready_mode = 0;
        out_ready  = 1'b1;
        w = flat_win(100);
        expect_window(w, 1'b1);
        in_win = w; in_last = 1'b1; in_valid = 1'b1;
        step();
        @(negedge clk);
        checks++;
        assert (out_valid === 1'b0) else begin errors++; $error("FAIL latency_early got out_valid=%b required 0", out_valid); end
        checks++;
        assert (in_ready === 1'b1) else begin errors++; $error("FAIL final_beat_ready got %b required 1", in_ready); end
        step();
        @(negedge clk);
        checks++;
        assert (out_valid === 1'b1) else begin errors++; $error("FAIL latency_2 got out_valid=%b required 1", out_valid); end
        in_valid = 1'b0;
        drain();

        // Directed windows back-to-back at full rate.
        w = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                w[((r*4+c)*CH)*CW +: CW] = 8'(40 * c);
        send(w, 1'b0);
        w = '0;
        for (int r = 1; r < 3; r++)
            for (int k = 0; k < 4 * CH; k++)
                w[(r*4*CH + k)*CW +: CW] = 8'd255;
        send(w, 1'b1);
        send(~w, 1'b0);
        w = '0;
        for (int ch = 0; ch < CH; ch++)
            w[((1*4+1)*CH+ch)*CW +: CW] = 8'd255;
        send(w, 1'b1);
        drain();

        // Back-pressure pattern 1,0,0,1 with random windows.
        ready_mode = 1;
        for (int k = 0; k < 8; k++)
            send(rand_win(), 1'($urandom_range(0, 1)));
        drain();

        // Random back-pressure.
        ready_mode = 2;
        for (int k = 0; k < 12; k++)
            send(rand_win(), 1'($urandom_range(0, 1)));
        ready_mode = 0;
        drain();

        // Reset mid-window with the output register stalled on live data.
        ready_mode = 3;
        out_ready  = 1'b0;
        w = flat_win(200);
        expect_window(w, 1'b1);
        in_win = w; in_last = 1'b1; in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        in_win = rand_win(); in_last = 1'b1; in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        expq.delete();
        @(negedge clk);
        checks++;
        assert (out_valid === 1'b0) else begin errors++; $error("FAIL midrst_out_valid got %b required 0", out_valid); end
        checks++;
        assert (out_pix === '0) else begin errors++; $error("FAIL midrst_out_pix got %h required 0", out_pix); end
        checks++;
        assert (out_last === 1'b0) else begin errors++; $error("FAIL midrst_out_last got %b required 0", out_last); end
        checks++;
        assert (in_ready === 1'b0) else begin errors++; $error("FAIL midrst_in_ready got %b required 0", in_ready); end
        checks++;
        assert (dut.beat_cnt === 2'd0) else begin errors++; $error("FAIL midrst_beat_cnt got %0d required 0", dut.beat_cnt); end
        ready_mode = 0;
        send(rand_win(), 1'b1);
        send(flat_win(37), 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
